hs_rx: RTL and testbench
========================

# hs_rx

Receive endpoint of a four-phase req/ack handshake crossing into the CK domain. It synchronizes an asynchronous request, captures the accompanying bundled data into a holding register, and presents it on a valid/ready interface. It returns the acknowledge to the sender and maintains a transfer count and a sticky protocol-error flag. It sits directly downstream of the sender's DFF-based request/data registers and is the standard consumer for metastability checks built on DFF/DFFx cells.

## Interface

Parameters:
- WIDTH, 8, width of the bundled data word
- SYNC_STAGES, 2, flops in the req synchronizer chain (legal range 2..4)
- CNT_W, 16, width of the transfer counter

Ports:
- CK  input  1  rising-edge clock
- RS  input  1  asynchronous, active-low reset
- req_a  input  1  sender request, asynchronous to CK
- data_a  input  WIDTH  bundled data; the sender holds it stable from req_a rising until ack is seen high
- ack  output  1  acknowledge to the sender, registered
- out_valid  output  1  captured word available
- out_ready  input  1  consumer accepts the word
- out_data  output  WIDTH  captured word
- xfer_cnt  output  CNT_W  completed transfers, wraps modulo 2^CNT_W
- proto_err  output  1  sticky; set on a protocol violation

## Operation

- req_a passes through a SYNC_STAGES flop chain to produce req_s. No other logic samples req_a.
- data_a is sampled only in the capture cycle, once req_s is high. Its stability is guaranteed by the bundled-data contract.
- FSM states:
  - IDLE: ack=0, out_valid=0. If req_s=1, load out_data from data_a, set out_valid=1, go to HOLD.
  - HOLD: out_valid=1 and out_data is frozen. On out_valid&out_ready: clear out_valid, set ack=1, increment xfer_cnt, go to ACK.
  - ACK: ack=1. If req_s=0, clear ack and go to IDLE.
- Protocol violation: req_s falling while in HOLD sets proto_err.
  - The captured word is still delivered.
  - The FSM then enters ACK with req_s already low, so ack is high for exactly one cycle before IDLE.
- proto_err is cleared only by RS.
- out_ready is ignored in IDLE and ACK.
- xfer_cnt wraps from 2^CNT_W-1 to 0 without a flag.

## Timing

- Reset (RS=0, asynchronous): all of the following clear immediately and hold while RS=0.
  - Synchronizer flops = 0
  - State = IDLE, ack = 0, out_valid = 0
  - out_data = 0, xfer_cnt = 0, proto_err = 0
- Reset release: takes effect on the first CK edge after RS rises. A req_a already high at release is handled as a new request.
- Request latency: counting edge 1 as the first edge at which req_a is sampled 1, out_valid is high after edge SYNC_STAGES+1. This is 3 edges for the default configuration.
- Accept-to-ack: ack rises on the same edge that consumes out_valid&out_ready. No combinational path from out_ready to ack.
- Ack release: ack falls on the edge after req_s is seen 0 in ACK. This is SYNC_STAGES+1 edges after req_a falls.
- Back-to-back: minimum full cycle per word is 2×(SYNC_STAGES+1)+1 CK cycles plus sender delay. A new rising req_s is accepted in the same cycle the FSM returns to IDLE.
- A req_a pulse shorter than one CK period may be missed. This is legal and has no side effect unless the pulse reaches req_s.
- Reset mid-transfer drops any held word and ack immediately. The sender must restart its four-phase cycle.

## Structure

- Package hs_pkg:
  - state enum hs_state_t {IDLE, HOLD, ACK}, 2-bit encoding
  - localparam bounds for SYNC_STAGES
- Sub-module sync_chain:
  - parameter SYNC_STAGES
  - ports CK, RS, d, q
  - plain DFF chain with async active-low clear
  - the only place a DFFx metastability model is substituted during formal runs
- hs_rx holds the FSM, the data register, the counter, and the error flag.

## Test plan

- Reset and basic transfer: RS low 3 cycles, then req_a=1 with data_a=8'hA5 and out_ready=1. Required response:
  - out_valid rises after edge 3, out_data=8'hA5
  - ack rises on the next edge, xfer_cnt=1
  - after req_a drops, ack falls 3 edges later
- Backpressure: out_ready=0 for 10 cycles with data_a=8'h3C. Required: out_valid stays high and out_data stays 8'h3C throughout; ack stays 0 until out_ready=1.
- Protocol violation: drop req_a while in HOLD. Required: proto_err=1; the word is still delivered; ack is high for exactly 1 cycle; proto_err stays 1 through 5 further clean transfers.
- Counter wrap: with CNT_W=4, perform 17 transfers. Required: xfer_cnt reads 1 at the end.
- Reset mid-operation: assert RS while in HOLD and while in ACK. Required: ack, out_valid and xfer_cnt go to 0 in the same cycle, with no CK edge needed; after release, a held-high req_a produces a fresh capture.
- Glitch: a req_a pulse of half a CK period placed between edges. Required: no out_valid, no ack, xfer_cnt unchanged.

Source files
------------

// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types and bounds for the hs_rx handshake receiver
package hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } hs_state_t;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - plain flop chain bringing an asynchronous level into the CK domain
module sync_chain
    import hs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic CK,
    input  logic RS,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES out of range");
    end

    logic [SYNC_STAGES-1:0] ff;

    // Formal runs swap these flops for metastability-modelling cells; keep them bare.
    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            ff <= '0;
        end else begin
            ff <= {ff[SYNC_STAGES-2:0], d};
        end
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/hs_rx.sv
// rtl/hs_rx.sv - four-phase req/ack receive endpoint presenting bundled data on valid/ready
module hs_rx
    import hs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CK,
    input  logic             RS,
    input  logic             req_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             proto_err
);

    logic      req_s;
    hs_state_t state;
    hs_state_t state_next;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .CK (CK),
        .RS (RS),
        .d  (req_a),
        .q  (req_s)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_s)     state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACK;
            ACK:     if (!req_s)    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // data_a is only trusted in the capture cycle, where the sender's bundling guarantees stability.
    always_ff @(posedge CK or negedge RS) begin
        if (!RS) begin
            out_data  <= '0;
            xfer_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (state == IDLE && req_s) begin
                out_data <= data_a;
            end
            if (state == HOLD && out_ready) begin
                xfer_cnt <= xfer_cnt + CNT_W'(1);
            end
            if (state == HOLD && !req_s) begin
                proto_err <= 1'b1;
            end
        end
    end

    // Both outputs decode straight from the state flops, so out_ready never reaches ack combinationally.
    assign ack       = (state == ACK);
    assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_hs_rx.sv
// tb/tb_hs_rx.sv - randomized self-checking bench for hs_rx against an edge-count timing model
module tb_hs_rx;

    localparam int W   = 8;
    localparam int SS  = 2;
    localparam int CW  = 4;
    localparam int LAT = SS + 1;

    logic          CK = 1'b0;
    logic          RS;
    logic          req_a;
    logic [W-1:0]  data_a;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] xfer_cnt;
    logic          proto_err;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic exp_proto = 1'b0;
    logic [W-1:0] sent_q[$];

    hs_rx #(.WIDTH(W), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
        .CK        (CK),
        .RS        (RS),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack       (ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .xfer_cnt  (xfer_cnt),
        .proto_err (proto_err)
    );

    always #5 CK = ~CK;

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_xfer(input logic [W-1:0] d, input int delay, input string tag);
        logic [W-1:0] exp_word;
        data_a = d;
        req_a  = 1'b1;
        sent_q.push_back(d);
        repeat (LAT - 1) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s early_valid got %b exp 0", tag, out_valid);
        end
        tick();
        exp_word = sent_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_word) begin
            errors++;
            $display("FAIL %s capture got valid=%b data=%h exp valid=1 data=%h", tag, out_valid, out_data, exp_word);
        end
        for (int i = 0; i < delay; i++) begin
            out_ready = 1'b0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_word || ack !== 1'b0) begin
                errors++;
                $display("FAIL %s hold got valid=%b data=%h ack=%b exp 1 %h 0", tag, out_valid, out_data, ack, exp_word);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        checks++;
        if (ack !== 1'b1 || out_valid !== 1'b0 || xfer_cnt !== CW'(exp_cnt) || proto_err !== exp_proto) begin
            errors++;
            $display("FAIL %s accept got ack=%b valid=%b cnt=%0d err=%b exp 1 0 %0d %b",
                     tag, ack, out_valid, xfer_cnt, proto_err, exp_cnt, exp_proto);
        end
        req_a = 1'b0;
        repeat (LAT - 1) tick();
        checks++;
        if (ack !== 1'b1) begin
            errors++;
            $display("FAIL %s ack_early_fall got %b exp 1", tag, ack);
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_release got %b exp 0", tag, ack);
        end
    endtask

    task automatic test_reset();
        RS = 1'b0;
        req_a = 1'b0;
        data_a = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (ack !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || xfer_cnt !== '0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset got ack=%b valid=%b data=%h cnt=%0d err=%b exp all 0",
                     ack, out_valid, out_data, xfer_cnt, proto_err);
        end
        RS = 1'b1;
        exp_cnt = 0;
        exp_proto = 1'b0;
    endtask

    task automatic test_basic();
        do_xfer(8'hA5, 0, "basic");
    endtask

    task automatic test_backpressure();
        do_xfer(8'h3C, 10, "backpressure");
    endtask

    task automatic test_proto_err();
        logic [W-1:0] d;
        d = W'($urandom);
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL proto_pre got %b exp 0", proto_err);
        end
        data_a = d;
        req_a = 1'b1;
        repeat (LAT) tick();
        req_a = 1'b0;
        repeat (LAT + 1) tick();
        exp_proto = 1'b1;
        checks++;
        if (proto_err !== 1'b1 || out_valid !== 1'b1 || out_data !== d) begin
            errors++;
            $display("FAIL proto_set got err=%b valid=%b data=%h exp 1 1 %h", proto_err, out_valid, out_data, d);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        checks++;
        if (ack !== 1'b1 || out_valid !== 1'b0 || xfer_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL proto_deliver got ack=%b valid=%b cnt=%0d exp 1 0 %0d", ack, out_valid, xfer_cnt, exp_cnt);
        end
        tick();
        checks++;
        if (ack !== 1'b0) begin
            errors++;
            $display("FAIL proto_ack_one_cycle got %b exp 0", ack);
        end
        for (int i = 0; i < 5; i++) begin
            do_xfer(W'($urandom), $urandom_range(0, 3), "proto_clean");
        end
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL proto_sticky got %b exp 1", proto_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] d;
        d = W'($urandom);
        data_a = d;
        req_a = 1'b1;
        repeat (LAT) tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_hold_entry got %b exp 1", out_valid);
        end
        #2 RS = 1'b0;
        #1;
        exp_cnt = 0;
        exp_proto = 1'b0;
        checks++;
        if (ack !== 1'b0 || out_valid !== 1'b0 || xfer_cnt !== '0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_hold got ack=%b valid=%b cnt=%0d err=%b exp 0 0 0 0", ack, out_valid, xfer_cnt, proto_err);
        end
        tick();
        RS = 1'b1;
        d = W'($urandom);
        data_a = d;
        repeat (LAT) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== d) begin
            errors++;
            $display("FAIL rst_recapture1 got valid=%b data=%h exp 1 %h", out_valid, out_data, d);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (ack !== 1'b1 || xfer_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL rst_enter_ack got ack=%b cnt=%0d exp 1 1", ack, xfer_cnt);
        end
        #2 RS = 1'b0;
        #1;
        checks++;
        if (ack !== 1'b0 || out_valid !== 1'b0 || xfer_cnt !== '0) begin
            errors++;
            $display("FAIL rst_in_ack got ack=%b valid=%b cnt=%0d exp 0 0 0", ack, out_valid, xfer_cnt);
        end
        tick();
        RS = 1'b1;
        sent_q.delete();
        req_a = 1'b0;
        do_xfer(W'($urandom), 1, "rst_recapture2");
    endtask

    task automatic test_counter_wrap();
        RS = 1'b0;
        tick();
        RS = 1'b1;
        exp_cnt = 0;
        exp_proto = 1'b0;
        for (int i = 0; i < 17; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            do_xfer(W'($urandom), $urandom_range(0, 3), "wrap");
        end
        checks++;
        if (xfer_cnt !== CW'(1)) begin
            errors++;
            $display("FAIL wrap_final got %0d exp 1", xfer_cnt);
        end
    endtask

    task automatic test_glitch();
        bit seen;
        seen = 1'b0;
        tick();
        #2 req_a = 1'b1;
        #5 req_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0 || ack !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL glitch_response got activity=1 exp 0");
        end
        checks++;
        if (xfer_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL glitch_cnt got %0d exp %0d", xfer_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_proto_err();
        test_reset_mid();
        test_counter_wrap();
        test_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
